gpio_periph: RTL

GPIO_PERIPH -- requirements
Module: gpio_periph

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_if.sv | 17 +
 rtl/gpio_sync_edge.sv | 50 +++++
 rtl/gpio_periph.sv | 110 +++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register offsets and bus helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_pkg;

    // Word offsets inside the 32-byte window (byte offset >> 2).
    typedef enum logic [2:0] {
        OFS_IN       = 3'd0,  // 0x00 synchronised pin levels, read-only
        OFS_IRQ_EN   = 3'd1,  // 0x04 interrupt enable
        OFS_IRQ_PEND = 3'd2,  // 0x08 pending edges, write-1-to-clear
        OFS_EDGE_SEL = 3'd3,  // 0x0C 1 = falling, 0 = rising
        OFS_OUT      = 3'd4,  // 0x10 output register
        OFS_SET      = 3'd5,  // 0x14 OUT |= d
        OFS_CLR      = 3'd6,  // 0x18 OUT &= ~d
        OFS_TOG      = 3'd7   // 0x1C OUT ^= d
    } gpio_ofs_e;

    // Warm-up counter value at which edge detection becomes live.
    localparam logic [1:0] WARM_DONE = 2'd3;

    // Expand per-byte enables into a per-bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_if.sv
// Register bus bundle for the GPIO peripheral.
// Latency: n/a (wires only); read data is registered by the slave.
// Backpressure: none; every access completes in one cycle.
// Signals: address (byte), data_in (write data), width (byte enables),
//          write (strobe), data_out (registered read data).
interface gpio_if;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [3:0]  width;
    logic        write;
    logic [31:0] data_out;

    modport master (output address, output data_in, output width, output write,
                    input  data_out);
    modport slave  (input  address, input  data_in, input  width, input  write,
                    output data_out);
endinterface

// File: rtl/gpio_sync_edge.sv
// Pin synchroniser (s1, s2), history flop (s3) and per-bit edge detector.
// Latency: pin change before edge k gives evt_o during the cycle after edge k+1.
// Backpressure: none; evt_o is a one-cycle pulse per selected edge.
// Ports: clk, rst (sync, active-high), gpio_i (async pins), edge_sel_i (1=falling),
//        sync_o (s2, synchronised level), evt_o (selected edge seen this cycle).
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_i,
    input  logic [WIDTH-1:0] edge_sel_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] evt_o
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [1:0]       warm_q;
    logic [WIDTH-1:0] rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            warm_q <= '0;
        end else begin
            s1_q <= gpio_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            // Saturating: once the pipeline holds real pin history it stays live.
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign sync_o = s2_q;
    assign rise   = s2_q & ~s3_q;
    assign fall   = ~s2_q & s3_q;

    // Edge selection depends only on pin history, so flipping edge_sel_i
    // on a steady pin can never produce an event. The zeros shifted in by
    // reset would look like edges for pins already high; gate them off.
    assign evt_o = (warm_q == WARM_DONE) ? ((edge_sel_i & fall) | (~edge_sel_i & rise))
                                         : '0;

endmodule

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO block: output register with set/clear/toggle aliases,
// synchronised inputs with edge-triggered pending bits and a level interrupt.
// Latency: register writes take effect at the write edge; reads return one cycle later.
// Backpressure: none; the bus is always ready.
// Ports: clk, rst (sync, active-high), bus (gpio_if slave), gpio_in (async pins),
//        gpio_out (OUT register), irq (|(PEND & IRQ_EN)).
module gpio_periph
    import gpio_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter logic [9:0] BASE_ADDR = 10'h40
) (
    input  logic             clk,
    input  logic             rst,
    gpio_if.slave            bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] pin_sync, pin_evt;
    logic [31:0]      be_mask;
    logic [WIDTH-1:0] wbits, wmask;
    logic [WIDTH-1:0] rsel;
    logic             hit, we;
    gpio_ofs_e        ofs;
    logic             unused_bits;

    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .gpio_i     (gpio_in),
        .edge_sel_i (edge_sel_q),
        .sync_o     (pin_sync),
        .evt_o      (pin_evt)
    );

    // Byte lanes and pins beyond WIDTH simply have no storage behind them.
    assign unused_bits = ^{bus.data_in, be_mask, bus.address[1:0]};

    always_comb begin
        hit     = (bus.address[9:5] == BASE_ADDR[9:5]);
        ofs     = gpio_ofs_e'(bus.address[4:2]);
        we      = bus.write & hit;
        be_mask = byte_mask(bus.width);
        wmask   = be_mask[WIDTH-1:0];
        wbits   = bus.data_in[WIDTH-1:0] & wmask;

        out_d      = out_q;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        pend_d     = pend_q;

        if (we) begin
            case (ofs)
                OFS_IRQ_EN:   irq_en_d   = (irq_en_q & ~wmask) | wbits;
                OFS_IRQ_PEND: pend_d     = pend_q & ~wbits;
                OFS_EDGE_SEL: edge_sel_d = (edge_sel_q & ~wmask) | wbits;
                OFS_OUT:      out_d      = (out_q & ~wmask) | wbits;
                OFS_SET:      out_d      = out_q | wbits;
                OFS_CLR:      out_d      = out_q & ~wbits;
                OFS_TOG:      out_d      = out_q ^ wbits;
                default:      ;  // IN is read-only
            endcase
        end
        // Applied after the W1C so a fresh edge survives a same-cycle clear.
        pend_d = pend_d | pin_evt;

        case (ofs)
            OFS_IN:       rsel = pin_sync;
            OFS_IRQ_EN:   rsel = irq_en_q;
            OFS_IRQ_PEND: rsel = pend_q;
            OFS_EDGE_SEL: rsel = edge_sel_q;
            OFS_OUT:      rsel = out_q;
            default:      rsel = '0;  // SET/CLR/TOG are write-only
        endcase

        rdata_d = '0;
        if (hit) begin
            rdata_d[WIDTH-1:0] = rsel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            irq_en_q   <= '0;
            pend_q     <= '0;
            edge_sel_q <= '0;
            rdata_q    <= '0;
        end else begin
            out_q      <= out_d;
            irq_en_q   <= irq_en_d;
            pend_q     <= pend_d;
            edge_sel_q <= edge_sel_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gpio_out     = out_q;
    assign irq          = |(pend_q & irq_en_q);
    assign bus.data_out = rdata_q;

endmodule
